sum16_rr_scheduler: RTL and testbench



---
 rtl/sum16_rr_scheduler.sv | 150 +++++++++++++++
 tb/tb_sum16_rr_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum16_rr_scheduler.sv
// -----------------------------------------------------------------------------
// sum16_rr_scheduler
//
// Shares one 16-input fp32 reduction datapath between NUM_REQ requesters.
// A round-robin arbiter grants at most one 16-operand bundle per cycle. The
// bundle is registered onto the adder input, and the requester id is pushed
// into an in-order tag FIFO. Each result returned by the adder pops the FIFO
// head and is routed back to its owner as a one-cycle pulse.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is a combinational one-hot grant)
//   req_data          requester i bundle at [i*512 +: 512], operand k at [k*32 +: 32]
//   sum_valid/data    registered bundle driven into the adder
//   sum_result_valid  adder output valid / result
//   sum_result
//   resp_valid/data   registered one-hot result pulse and its value
//   inflight          tag FIFO occupancy (0..TAG_DEPTH)
//   busy              sum_valid or any operation in flight
//   err_orphan        sticky: a result arrived while nothing was in flight
// -----------------------------------------------------------------------------
module sum16_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*512-1:0] req_data,
  output logic                   sum_valid,
  output logic [511:0]           sum_data,
  input  logic                   sum_result_valid,
  input  logic [31:0]            sum_result,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic [ID_W+1:0]        inflight,
  output logic                   busy,
  output logic                   err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = ID_W + 2;

  logic [ID_W-1:0]    rr_q;
  logic [ID_W-1:0]    tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               sum_valid_q;
  logic [511:0]       sum_data_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [31:0]        resp_data_q;
  logic               err_orphan_q;

  logic [511:0]       bundle [NUM_REQ];
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic               pop;
  logic               full;
  logic               can_push;
  logic               accept;
  logic [ID_W-1:0]    rr_d;
  logic [CNT_W-1:0]   count_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign bundle[gi] = req_data[gi*512 +: 512];
      // Grant is forced low while in reset so nothing can be accepted.
      assign req_ready[gi] = !rst && grant_found && can_push &&
                             (grant_id == ID_W'(gi));
    end
  endgenerate

  // Round-robin search: the winner is the valid requester with the smallest
  // ascending distance (with wrap) from the rr pointer.
  always_comb begin
    int best_d;
    int d;
    best_d   = NUM_REQ;
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(rr_q)) % NUM_REQ;
      if (req_valid[i] && d < best_d) begin
        best_d   = d;
        grant_id = ID_W'(i);
      end
    end
    grant_found = (best_d < NUM_REQ);
  end

  assign pop      = sum_result_valid && (count_q != '0);
  assign full     = (count_q == CNT_W'(TAG_DEPTH));
  // A full FIFO still takes a push in the same cycle it pops.
  assign can_push = !full || pop;
  assign accept   = |(req_valid & req_ready);
  assign rr_d     = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
  assign count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);

  // Tag storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[wr_ptr_q] <= grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sum_valid_q  <= 1'b0;
      sum_data_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      sum_valid_q <= accept;
      count_q     <= count_d;
      if (accept) begin
        sum_data_q <= bundle[grant_id];
        rr_q       <= rr_d;
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        resp_valid_q <= NUM_REQ'(1) << tag_mem[rd_ptr_q];
        resp_data_q  <= sum_result;
      end else begin
        resp_valid_q <= '0;
      end
      // A result with nothing in flight cannot be attributed to anyone.
      if (sum_result_valid && (count_q == '0)) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign inflight   = count_q;
  assign busy       = sum_valid_q | (count_q != '0);
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sum16_rr_scheduler.sv
module tb_sum16_rr_scheduler;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*512-1:0] req_data;
  logic             sum_valid;
  logic [511:0]     sum_data;
  logic             sum_result_valid;
  logic [31:0]      sum_result;
  logic [N-1:0]     resp_valid;
  logic [31:0]      resp_data;
  logic [IDW+1:0]   inflight;
  logic             busy;
  logic             err_orphan;

  sum16_rr_scheduler #(.NUM_REQ(N), .ID_W(IDW), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .sum_valid(sum_valid), .sum_data(sum_data),
    .sum_result_valid(sum_result_valid), .sum_result(sum_result),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inflight(inflight), .busy(busy), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---- fp32 helpers for integer-valued operands ----
  function automatic int f32_to_int(input logic [31:0] f);
    int e;
    int mag;
    logic [23:0] m;
    if (f[30:0] == 31'd0) return 0;
    e   = int'(f[30:23]) - 127;
    m   = {1'b1, f[22:0]};
    mag = int'(m >> (23 - e));
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] int_to_f32(input int v);
    logic [31:0] m;
    logic [31:0] sh;
    int p;
    if (v == 0) return 32'd0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int b = 0; b < 31; b++) if (m[b]) p = b;
    sh = m << (23 - p);
    return {(v < 0), 8'(127 + p), sh[22:0]};
  endfunction

  // Reference reduction: exact sum, negative results clamp to zero.
  function automatic logic [31:0] bundle_sum(input logic [511:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 16; k++) s += f32_to_int(b[k*32 +: 32]);
    if (s < 0) s = 0;
    return int_to_f32(s);
  endfunction

  // ---- adder model (environment) ----
  typedef struct { int due; logic [31:0] val; } pend_t;
  pend_t add_q[$];
  logic stall;
  int   release_req  = 0;
  int   release_done = 0;
  int   inject_req   = 0;
  int   inject_done  = 0;

  initial begin
    int cyc;
    pend_t p;
    cyc = 0;
    sum_result_valid = 1'b0;
    sum_result = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        add_q.delete();
        sum_result_valid = 1'b0;
        sum_result = 32'd0;
      end else begin
        if (sum_valid) add_q.push_back('{cyc + LAT, bundle_sum(sum_data)});
        sum_result_valid = 1'b0;
        if (add_q.size() > 0 && add_q[0].due <= cyc &&
            (!stall || release_req > release_done)) begin
          p = add_q.pop_front();
          sum_result_valid = 1'b1;
          sum_result = p.val;
          if (stall) release_done++;
        end else if (inject_req > inject_done) begin
          sum_result_valid = 1'b1;
          sum_result = $urandom;
          inject_done++;
        end
      end
    end
  end

  // ---- reference model + scoreboard push ----
  typedef struct { int id; logic [31:0] val; } exp_t;
  exp_t exp_q[$];

  initial begin
    int   rr_m;
    int   occ_m;
    logic err_m;
    logic issued_m;
    int   w;
    int   idx;
    logic pop_m;
    logic [N-1:0] exp_ready;
    rr_m = 0; occ_m = 0; err_m = 1'b0; issued_m = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err_orphan", err_orphan, 0);
        rr_m = 0; occ_m = 0; err_m = 1'b0; issued_m = 1'b0;
        exp_q.delete();
      end else begin
        chk("inflight", inflight, occ_m);
        chk("err_orphan", err_orphan, err_m);
        chk("busy", busy, (issued_m || occ_m != 0));
        pop_m = sum_result_valid && (occ_m > 0);
        if (sum_result_valid && occ_m == 0) err_m = 1'b1;
        w = -1;
        for (int d = 0; d < N; d++) begin
          idx = (rr_m + d) % N;
          if (w < 0 && req_valid[idx]) w = idx;
        end
        exp_ready = '0;
        if (w >= 0 && (occ_m < DEPTH || pop_m)) exp_ready[w] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        issued_m = (exp_ready != '0);
        if (issued_m) begin
          exp_q.push_back('{w, bundle_sum(req_data[w*512 +: 512])});
          rr_m = (w + 1) % N;
          occ_m++;
        end
        if (pop_m) occ_m--;
      end
    end
  end

  // ---- monitor: pops expectations on every response pulse ----
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          $display("resp: owner=%0h data=0x%08h (expect owner=%0h data=0x%08h)",
                   resp_valid, resp_data, 1 << e.id, e.val);
          chk("resp_owner", resp_valid, 1 << e.id);
          chk("resp_data", resp_data, e.val);
        end
      end
    end
  end

  // ---- stimulus ----
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input int r, input int v);
    for (int k = 0; k < 16; k++) req_data[r*512 + k*32 +: 32] = int_to_f32(v);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || add_q.size() != 0) && b < 300) begin
      tick(1);
      b++;
    end
    chk("drain_empty", exp_q.size(), 0);
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    stall = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // 1: single request, 16 x 1.0
    set_all(2, 1);
    req_valid = 4'b0100;
    #1 chk("t1_grant", req_ready, 4'b0100);
    tick(1);
    req_valid = '0;
    drain();

    // 2: all four valid for 8 cycles, requester i sends all (i+1)
    for (int r = 0; r < N; r++) set_all(r, r + 1);
    req_valid = 4'b1111;
    tick(8);
    req_valid = '0;
    drain();

    // 3: stalled adder fills the tag FIFO, then one release
    stall = 1'b1;
    for (int r = 0; r < N; r++) set_all(r, r + 2);
    req_valid = 4'b1111;
    tick(12);
    chk("t3_full_inflight", inflight, DEPTH);
    chk("t3_full_ready", req_ready, 0);
    release_req++;
    tick(1);
    tick(1);
    chk("t3_after_release", inflight, DEPTH);
    req_valid = '0;
    stall = 1'b0;
    drain();

    // 4: reset with three operations in flight
    stall = 1'b1;
    req_valid = 4'b1111;
    tick(3);
    req_valid = '0;
    tick(1);
    chk("t4_inflight_pre", inflight, 3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    stall = 1'b0;
    chk("t4_inflight_post", inflight, 0);
    req_valid = 4'b1111;
    #1 chk("t4_first_grant", req_ready, 4'b0001);
    tick(1);
    req_valid = '0;
    drain();

    // 5: orphan result, then a normal transaction
    inject_req++;
    tick(3);
    chk("t5_err_set", err_orphan, 1);
    set_all(1, 3);
    req_valid = 4'b0010;
    tick(1);
    req_valid = '0;
    drain();
    chk("t5_err_sticky", err_orphan, 1);

    // 6: negative sum clamps to zero
    set_all(3, -1);
    req_valid = 4'b1000;
    tick(1);
    req_valid = '0;
    drain();

    // random traffic with occasional adder stalls
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++)
        for (int k = 0; k < 16; k++)
          req_data[r*512 + k*32 +: 32] = int_to_f32(int'($urandom_range(0, 16)) - 8);
      stall = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    req_valid = '0;
    stall = 1'b0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
